// File: rtl/msu_data_fetch_if.sv
// Bus bundle between the MSU register block, the data fetcher and the memory arbiter port.
// The slave modport is the fetcher's view; master is the view of whatever drives it.
interface msu_data_fetch_if #(
    parameter int MEM_AW = 24
);
    logic [31:0]       msu_data_addr;
    logic              msu_data_seek;
    logic              msu_data_req;
    logic [7:0]        msu_data_in;
    logic              msu_status_data_busy;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ack;
    logic [15:0]       mem_data;

    modport slave (
        input  msu_data_addr, msu_data_seek, msu_data_req, mem_ack, mem_data,
        output msu_data_in, msu_status_data_busy, mem_addr, mem_rd
    );

    modport master (
        output msu_data_addr, msu_data_seek, msu_data_req, mem_ack, mem_data,
        input  msu_data_in, msu_status_data_busy, mem_addr, mem_rd
    );
endinterface

// File: rtl/msu_data_fetch.sv
// MSU-1 data port responder: streams bytes of the mounted data file from word memory
// through a small prefetch FIFO and presents the head byte to the MSU register block.
module msu_data_fetch #(
    parameter int MEM_AW     = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    msu_data_fetch_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FILL_LIMIT = CW'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [MEM_AW-1:0] r_fptr;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_skip_odd;
    logic              r_valid;
    logic              r_busy;
    logic [7:0]        r_dout;
    logic [7:0]        r_fifo [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic              w_push_lo;
    logic              w_push_hi;
    logic              w_pop;
    logic [1:0]        w_push_n;
    logic [PW-1:0]     w_hi_idx;
    logic              w_unused_addr;

    assign w_unused_addr = ^bus.msu_data_addr[31:MEM_AW+1];

    // Decode this cycle's FIFO traffic; a seek overrides both push and pop.
    always_comb begin
        w_push_lo = 1'b0;
        w_push_hi = 1'b0;
        w_pop     = 1'b0;
        w_hi_idx  = r_wptr;
        if (!bus.msu_data_seek) begin
            w_push_hi = bus.mem_ack && (r_state == S_FETCH);
            w_push_lo = w_push_hi && !r_skip_odd;
            w_pop     = bus.msu_data_req && r_valid && !r_busy && (r_count != CW'(0));
        end else begin
            w_pop     = 1'b0;
        end
        w_push_n = {1'b0, w_push_lo} + {1'b0, w_push_hi};
        if (w_push_lo) begin
            w_hi_idx = r_wptr + PW'(1);
        end else begin
            w_hi_idx = r_wptr;
        end
    end

    // Control FSM, stream pointer, FIFO bookkeeping and busy flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_fptr     <= {MEM_AW{1'b0}};
            r_mem_addr <= {MEM_AW{1'b0}};
            r_mem_rd   <= 1'b0;
            r_skip_odd <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_wptr     <= PW'(0);
            r_rptr     <= PW'(0);
            r_count    <= CW'(0);
        end else if (bus.msu_data_seek) begin
            r_fptr     <= bus.msu_data_addr[MEM_AW:1];
            r_skip_odd <= bus.msu_data_addr[0];
            r_valid    <= 1'b1;
            r_busy     <= 1'b1;
            r_wptr     <= PW'(0);
            r_rptr     <= PW'(0);
            r_count    <= CW'(0);
            // An outstanding read can't be cancelled; its data is simply never pushed.
            case (r_state)
                S_FETCH, S_DRAIN: begin
                    if (bus.mem_ack) begin
                        r_state  <= S_IDLE;
                        r_mem_rd <= 1'b0;
                    end else begin
                        r_state  <= S_DRAIN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end else begin
            r_count <= r_count + CW'(w_push_n) - CW'(w_pop);
            r_wptr  <= r_wptr + PW'(w_push_n);
            r_rptr  <= r_rptr + PW'(w_pop);
            if (w_pop && (r_count == CW'(1)) && (w_push_n == 2'd0)) begin
                r_busy <= 1'b1;
            end else if (r_count != CW'(0)) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_valid && (r_count <= FILL_LIMIT)) begin
                        r_state    <= S_FETCH;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_fptr;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        r_state    <= S_IDLE;
                        r_mem_rd   <= 1'b0;
                        r_fptr     <= r_fptr + MEM_AW'(1);
                        r_skip_odd <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (bus.mem_ack) begin
                        r_state  <= S_IDLE;
                        r_mem_rd <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_rd <= 1'b0;
                end
            endcase
        end
    end

    // Byte storage; occupancy lives in the pointers so the array needs no reset.
    always_ff @(posedge CLK) begin
        if (w_push_lo) begin
            r_fifo[r_wptr] <= bus.mem_data[7:0];
        end
        if (w_push_hi) begin
            r_fifo[w_hi_idx] <= bus.mem_data[15:8];
        end
    end

    // Output byte tracks the FIFO head and holds its last value while empty.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dout <= 8'h00;
        end else if (r_count != CW'(0)) begin
            r_dout <= r_fifo[r_rptr];
        end
    end

    assign bus.msu_data_in          = r_dout;
    assign bus.msu_status_data_busy = r_busy;
    assign bus.mem_addr             = r_mem_addr;
    assign bus.mem_rd               = r_mem_rd;
endmodule

// File: tb/tb_msu_data_fetch.sv
// Directed bench for msu_data_fetch: a small word memory with adjustable latency
// answers the fetcher while each scenario task checks the byte stream and handshakes.
module tb_msu_data_fetch;
    localparam int MEM_AW = 24;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   ack_delay = 2;
    bit   mem_en    = 1'b1;
    bit   stray_ack = 1'b0;
    logic [MEM_AW-1:0] rd_log[$];

    msu_data_fetch_if #(.MEM_AW(MEM_AW)) bus ();

    msu_data_fetch #(.MEM_AW(MEM_AW), .FIFO_DEPTH(16)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] mem_word(input logic [MEM_AW-1:0] a);
        if (a == 24'h000080) return 16'hBBAA;
        if (a == 24'h000081) return 16'hDDCC;
        return {a[7:0] ^ 8'hA5, a[7:0] ^ 8'h3C};
    endfunction

    function automatic logic [MEM_AW-1:0] log_at(input int i);
        if (i < rd_log.size()) return rd_log[i];
        return {MEM_AW{1'b1}};
    endfunction

    // Memory responder: logs each new request, acks after ack_delay cycles.
    initial begin : mem_model
        int wait_cnt;
        bit prev_rd;
        wait_cnt = 0;
        prev_rd  = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 16'h0000;
        forever begin
            @(posedge CLK);
            #1;
            if (mem_en) begin
                bus.mem_ack = 1'b0;
                if (bus.mem_rd && !prev_rd) rd_log.push_back(bus.mem_addr);
                if (bus.mem_rd) begin
                    if (wait_cnt >= ack_delay) begin
                        bus.mem_ack  = 1'b1;
                        bus.mem_data = mem_word(bus.mem_addr);
                        wait_cnt     = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                bus.mem_ack  = stray_ack;
                bus.mem_data = 16'h1234;
            end
            prev_rd = bus.mem_rd;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_seek(input logic [31:0] addr);
        bus.msu_data_addr = addr;
        bus.msu_data_seek = 1'b1;
        tick();
        bus.msu_data_seek = 1'b0;
    endtask

    task automatic do_req();
        bus.msu_data_req = 1'b1;
        tick();
        bus.msu_data_req = 1'b0;
    endtask

    task automatic wait_ready(input int max_cycles, input string tag);
        int n;
        n = 0;
        while (bus.msu_status_data_busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        n_vec++;
        if (bus.msu_status_data_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s: busy still %b after %0d cycles, want 0", tag, bus.msu_status_data_busy, n);
        end
    endtask

    task automatic test_reset();
        int rd_seen;
        rd_seen = 0;
        RST_N = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
        tick();
        n_vec++; if (bus.msu_data_in !== 8'h00) begin n_err++; $display("FAIL rst_dout: got %h want 00", bus.msu_data_in); end
        n_vec++; if (bus.msu_status_data_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.msu_status_data_busy); end
        n_vec++; if (bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL rst_mem_rd: got %b want 0", bus.mem_rd); end
        n_vec++; if (bus.mem_addr !== 24'h000000) begin n_err++; $display("FAIL rst_mem_addr: got %h want 000000", bus.mem_addr); end
        do_req();
        repeat (10) begin
            tick();
            if (bus.mem_rd === 1'b1) rd_seen++;
        end
        n_vec++; if (rd_seen != 0) begin n_err++; $display("FAIL preseek_no_fetch: got %0d mem_rd cycles want 0", rd_seen); end
        n_vec++; if (bus.msu_data_in !== 8'h00) begin n_err++; $display("FAIL preseek_dout: got %h want 00", bus.msu_data_in); end
    endtask

    task automatic test_seek_even();
        do_seek(32'h0000_0100);
        rd_log.delete();
        n_vec++; if (bus.msu_status_data_busy !== 1'b1) begin n_err++; $display("FAIL even_busy_set: got %b want 1", bus.msu_status_data_busy); end
        wait_ready(100, "even_ready");
        n_vec++; if (bus.msu_data_in !== 8'hAA) begin n_err++; $display("FAIL even_byte0: got %h want AA", bus.msu_data_in); end
        n_vec++; if (log_at(0) !== 24'h000080) begin n_err++; $display("FAIL even_addr0: got %h want 000080", log_at(0)); end
        do_req();
        tick();
        n_vec++; if (bus.msu_data_in !== 8'hBB) begin n_err++; $display("FAIL even_byte1: got %h want BB", bus.msu_data_in); end
        n_vec++; if (bus.msu_status_data_busy !== 1'b0) begin n_err++; $display("FAIL even_busy_clr: got %b want 0", bus.msu_status_data_busy); end
        do_req();
        tick();
        n_vec++; if (bus.msu_data_in !== 8'hCC) begin n_err++; $display("FAIL even_byte2: got %h want CC", bus.msu_data_in); end
        n_vec++; if (log_at(1) !== 24'h000081) begin n_err++; $display("FAIL even_addr1: got %h want 000081", log_at(1)); end
    endtask

    task automatic test_seek_odd();
        do_seek(32'h0000_0101);
        rd_log.delete();
        wait_ready(100, "odd_ready");
        n_vec++; if (bus.msu_data_in !== 8'hBB) begin n_err++; $display("FAIL odd_byte0: got %h want BB", bus.msu_data_in); end
        n_vec++; if (log_at(0) !== 24'h000080) begin n_err++; $display("FAIL odd_addr0: got %h want 000080", log_at(0)); end
        do_req();
        wait_ready(100, "odd_ready2");
        n_vec++; if (bus.msu_data_in !== 8'hCC) begin n_err++; $display("FAIL odd_byte1: got %h want CC", bus.msu_data_in); end
    endtask

    task automatic test_underrun();
        ack_delay = 20;
        do_seek(32'h0000_0100);
        wait_ready(200, "under_ready");
        n_vec++; if (bus.msu_data_in !== 8'hAA) begin n_err++; $display("FAIL under_byte0: got %h want AA", bus.msu_data_in); end
        do_req();
        tick();
        n_vec++; if (bus.msu_data_in !== 8'hBB) begin n_err++; $display("FAIL under_byte1: got %h want BB", bus.msu_data_in); end
        n_vec++; if (bus.msu_status_data_busy !== 1'b0) begin n_err++; $display("FAIL under_busy_pre: got %b want 0", bus.msu_status_data_busy); end
        do_req();
        n_vec++; if (bus.msu_status_data_busy !== 1'b1) begin n_err++; $display("FAIL under_busy_rise: got %b want 1", bus.msu_status_data_busy); end
        do_req();
        tick();
        n_vec++; if (bus.msu_status_data_busy !== 1'b1) begin n_err++; $display("FAIL under_busy_hold: got %b want 1", bus.msu_status_data_busy); end
        n_vec++; if (bus.msu_data_in !== 8'hBB) begin n_err++; $display("FAIL under_hold: got %h want BB", bus.msu_data_in); end
        wait_ready(100, "under_refill");
        n_vec++; if (bus.msu_data_in !== 8'hCC) begin n_err++; $display("FAIL under_byte2: got %h want CC", bus.msu_data_in); end
        do_req();
        tick();
        n_vec++; if (bus.msu_data_in !== 8'hDD) begin n_err++; $display("FAIL under_byte3: got %h want DD", bus.msu_data_in); end
    endtask

    task automatic test_drain();
        int n;
        ack_delay = 10;
        do_seek(32'h0000_0100);
        n = 0;
        while (!(bus.mem_rd === 1'b1 && bus.mem_addr === 24'h000080) && n < 60) begin
            tick();
            n++;
        end
        n_vec++; if (bus.mem_addr !== 24'h000080) begin n_err++; $display("FAIL drain_req_seen: got addr %h want 000080", bus.mem_addr); end
        repeat (2) tick();
        do_seek(32'h0000_0200);
        rd_log.delete();
        n_vec++; if (bus.mem_rd !== 1'b1) begin n_err++; $display("FAIL drain_rd_held: got %b want 1", bus.mem_rd); end
        n_vec++; if (bus.mem_addr !== 24'h000080) begin n_err++; $display("FAIL drain_addr_held: got %h want 000080", bus.mem_addr); end
        n = 0;
        while (rd_log.size() == 0 && n < 60) begin
            tick();
            n++;
        end
        n_vec++; if (log_at(0) !== 24'h000100) begin n_err++; $display("FAIL drain_next_addr: got %h want 000100", log_at(0)); end
        wait_ready(100, "drain_ready");
        n_vec++; if (bus.msu_data_in !== 8'h3C) begin n_err++; $display("FAIL drain_byte0: got %h want 3C", bus.msu_data_in); end
        do_req();
        tick();
        n_vec++; if (bus.msu_data_in !== 8'hA5) begin n_err++; $display("FAIL drain_byte1: got %h want A5", bus.msu_data_in); end
    endtask

    task automatic test_fill();
        ack_delay = 0;
        do_seek(32'h0000_0101);
        rd_log.delete();
        repeat (60) tick();
        n_vec++; if (rd_log.size() != 8) begin n_err++; $display("FAIL fill_reqs: got %0d want 8", rd_log.size()); end
        n_vec++; if (bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL fill_rd_idle: got %b want 0", bus.mem_rd); end
        n_vec++; if (bus.msu_data_in !== 8'hBB) begin n_err++; $display("FAIL fill_byte0: got %h want BB", bus.msu_data_in); end
        do_req();
        repeat (20) tick();
        n_vec++; if (rd_log.size() != 9) begin n_err++; $display("FAIL fill_resume: got %0d want 9", rd_log.size()); end
        n_vec++; if (log_at(8) !== 24'h000088) begin n_err++; $display("FAIL fill_resume_addr: got %h want 000088", log_at(8)); end
        n_vec++; if (bus.msu_data_in !== 8'hCC) begin n_err++; $display("FAIL fill_byte1: got %h want CC", bus.msu_data_in); end
    endtask

    task automatic test_reset_mid_fetch();
        int n;
        int rd_seen;
        mem_en = 1'b0;
        do_seek(32'h0000_0100);
        n = 0;
        while (bus.mem_rd !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_vec++; if (bus.mem_rd !== 1'b1) begin n_err++; $display("FAIL mid_rd_up: got %b want 1", bus.mem_rd); end
        #3;
        RST_N = 1'b0;
        #1;
        n_vec++; if (bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL mid_rst_rd: got %b want 0", bus.mem_rd); end
        n_vec++; if (bus.mem_addr !== 24'h000000) begin n_err++; $display("FAIL mid_rst_addr: got %h want 000000", bus.mem_addr); end
        n_vec++; if (bus.msu_data_in !== 8'h00) begin n_err++; $display("FAIL mid_rst_dout: got %h want 00", bus.msu_data_in); end
        n_vec++; if (bus.msu_status_data_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", bus.msu_status_data_busy); end
        #2;
        RST_N = 1'b1;
        tick();
        #2;
        stray_ack = 1'b1;
        tick();
        #2;
        stray_ack = 1'b0;
        rd_seen = 0;
        repeat (30) begin
            tick();
            if (bus.mem_rd === 1'b1) rd_seen++;
        end
        n_vec++; if (rd_seen != 0) begin n_err++; $display("FAIL mid_no_fetch: got %0d mem_rd cycles want 0", rd_seen); end
        n_vec++; if (bus.msu_data_in !== 8'h00) begin n_err++; $display("FAIL mid_dout_after: got %h want 00", bus.msu_data_in); end
        n_vec++; if (bus.msu_status_data_busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_after: got %b want 0", bus.msu_status_data_busy); end
    endtask

    initial begin : main
        bus.msu_data_addr = 32'h0000_0000;
        bus.msu_data_seek = 1'b0;
        bus.msu_data_req  = 1'b0;
        test_reset();
        test_seek_even();
        test_seek_odd();
        test_underrun();
        test_drain();
        test_fill();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
